// File: rtl/nand_toggle_bank.sv
// Bank of registered NAND-feedback toggles with a rising-edge counter on one selectable
// channel and a first-word-fall-through FIFO of edge timestamps.
module nand_toggle_bank #(
    parameter int unsigned  CHANNELS = 4,
    parameter int unsigned  DEPTH    = 4,
    parameter int unsigned  CNT_W    = 64,
    localparam int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned LVL_W    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                clr,
    input  logic [SEL_W-1:0]    sel,
    output logic [CHANNELS-1:0] osc,
    output logic [7:0]          status,
    output logic [CNT_W-1:0]    edges,
    output logic                ts_valid,
    input  logic                ts_ready,
    output logic [CNT_W-1:0]    ts_data,
    output logic [LVL_W-1:0]    ts_level,
    output logic                overflow
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned STAT_N = (CHANNELS < 8) ? CHANNELS : 8;

    logic [CHANNELS-1:0] osc_q, osc_d, osc_prev_q;
    logic [CNT_W-1:0]    tick_q, tick_d;
    logic [CNT_W-1:0]    edges_q, edges_d;
    logic [CNT_W-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                overflow_q, overflow_d;

    logic sel_ok;
    logic rise;
    logic fifo_full;
    logic fifo_empty;
    logic push_req;
    logic push;
    logic pop;

    assign osc_d = ~(osc_q & en);

    // osc_prev tracks every channel, so switching sel never fabricates an edge.
    assign sel_ok = (32'(sel) < CHANNELS);
    assign rise   = sel_ok & osc_q[sel] & ~osc_prev_q[sel];

    assign fifo_full  = (level_q == LVL_W'(DEPTH));
    assign fifo_empty = (level_q == '0);

    // clr wins over both FIFO operations in the same cycle.
    assign pop      = ~fifo_empty & ts_ready & ~clr;
    assign push_req = rise & ~clr;
    assign push     = push_req & (~fifo_full | pop);

    always_comb begin
        tick_d     = tick_q + CNT_W'(1);
        edges_d    = edges_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (clr) begin
            tick_d     = '0;
            edges_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (rise) begin
                edges_d = edges_q + CNT_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
            if (push_req && !push) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osc_q      <= '0;
            osc_prev_q <= '0;
            tick_q     <= '0;
            edges_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            osc_q      <= osc_d;
            osc_prev_q <= osc_q;
            tick_q     <= tick_d;
            edges_q    <= edges_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: ts_data is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tick_q;
        end
    end

    always_comb begin
        status             = '0;
        status[STAT_N-1:0] = osc_q[STAT_N-1:0];
    end

    assign osc      = osc_q;
    assign edges    = edges_q;
    assign ts_valid = ~fifo_empty;
    assign ts_data  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign ts_level = level_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_nand_toggle_bank.sv
// Scoreboard bench for nand_toggle_bank: a behavioural model pushes expected timestamps,
// a negedge monitor checks every output and pops on each accepted transfer.
module tb_nand_toggle_bank;

    localparam int unsigned CHANNELS = 4;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CNT_W    = 64;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned LVL_W    = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [CHANNELS-1:0] en;
    logic                clr;
    logic [SEL_W-1:0]    sel;
    logic [CHANNELS-1:0] osc;
    logic [7:0]          status;
    logic [CNT_W-1:0]    edges;
    logic                ts_valid;
    logic                ts_ready;
    logic [CNT_W-1:0]    ts_data;
    logic [LVL_W-1:0]    ts_level;
    logic                overflow;

    always #5 clk = ~clk;

    nand_toggle_bank #(
        .CHANNELS(CHANNELS),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (clr),
        .sel     (sel),
        .osc     (osc),
        .status  (status),
        .edges   (edges),
        .ts_valid(ts_valid),
        .ts_ready(ts_ready),
        .ts_data (ts_data),
        .ts_level(ts_level),
        .overflow(overflow)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, updated once per clock edge.
    bit              m_osc  [CHANNELS];
    bit              m_prev [CHANNELS];
    longint unsigned m_tick;
    longint unsigned m_edges;
    bit              m_ovf;
    longint unsigned sb_q [$];
    int              mon_pops  = 0;
    int              seen_pops = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CHANNELS; i++) begin
            m_osc[i]  = 1'b0;
            m_prev[i] = 1'b0;
        end
        m_tick    = 0;
        m_edges   = 0;
        m_ovf     = 1'b0;
        sb_q.delete();
        seen_pops = mon_pops;
    endtask

    function automatic bit rise_pending();
        return m_osc[int'(sel)] && !m_prev[int'(sel)];
    endfunction

    // Advance the model across one clock edge using the inputs held during that cycle.
    task automatic model_step();
        bit r      = rise_pending();
        bit popped = (mon_pops != seen_pops);
        int occ    = sb_q.size() + (popped ? 1 : 0);
        seen_pops = mon_pops;
        if (clr) begin
            sb_q.delete();
            m_tick  = 0;
            m_edges = 0;
            m_ovf   = 1'b0;
        end else begin
            if (r) begin
                m_edges++;
                if (occ < DEPTH || popped) sb_q.push_back(m_tick);
                else m_ovf = 1'b1;
            end
            m_tick++;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            m_prev[i] = m_osc[i];
            m_osc[i]  = en[i] ? !m_osc[i] : 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Called 1 time unit after a rising edge; checks reset values with no clock in between.
    task automatic async_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_osc", osc, 0);
        chk("rst_status", status, 0);
        chk("rst_edges", edges, 0);
        chk("rst_valid", ts_valid, 0);
        chk("rst_data", ts_data, 0);
        chk("rst_level", ts_level, 0);
        chk("rst_overflow", overflow, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares all outputs against the model and pops on accepted transfers.
    initial begin
        forever begin
            logic [CHANNELS-1:0] eo;
            @(negedge clk);
            for (int i = 0; i < CHANNELS; i++) eo[i] = m_osc[i];
            chk("osc", osc, eo);
            chk("status", status, 8'(eo));
            chk("edges", edges, m_edges);
            chk("level", ts_level, sb_q.size());
            chk("valid", ts_valid, (sb_q.size() != 0));
            chk("overflow", overflow, m_ovf);
            if (sb_q.size() != 0) begin
                chk("ts_data", ts_data, sb_q[0]);
                if (ts_ready && !clr && rst_n) begin
                    void'(sb_q.pop_front());
                    mon_pops++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        rst_n    = 1'b1;
        en       = '0;
        clr      = 1'b0;
        sel      = '0;
        ts_ready = 1'b0;
        #2;
        async_reset();

        // All channels toggling, nothing drained: fill then overflow.
        en = '1;
        sel = 0;
        ts_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            seen = ts_valid;
        end
        chk("first_valid", ts_valid, 1);
        chk("first_ts", ts_data, 1);
        repeat (10) step();
        chk("fill_level", ts_level, DEPTH);
        chk("overflow_set", overflow, 1);

        // Refill after clr, then push and pop together while full.
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_overflow", overflow, 0);
        for (int i = 0; i < 20 && sb_q.size() < DEPTH; i++) step();
        for (int i = 0; i < 4 && !rise_pending(); i++) step();
        chk("full_before_pp", ts_level, DEPTH);
        ts_ready = 1'b1;
        step();
        ts_ready = 1'b0;
        chk("pp_level", ts_level, DEPTH);
        chk("pp_overflow", overflow, 0);

        // Mid-stream reset, then continuous draining.
        async_reset();
        en = '1;
        sel = 0;
        ts_ready = 1'b1;
        repeat (16) begin
            step();
            chk("drain_level_le1", (ts_level <= 1), 1);
        end
        chk("drain_overflow", overflow, 0);

        // Disabled channel rises once then holds.
        async_reset();
        en = 4'b1011;
        sel = 2;
        ts_ready = 1'b0;
        repeat (8) step();
        chk("hold_edges", edges, 1);
        chk("hold_level", ts_level, 1);
        chk("hold_ts", ts_data, 1);

        // clr landing exactly on a rise cycle discards the push.
        async_reset();
        en = '1;
        sel = 0;
        repeat (5) step();
        for (int i = 0; i < 4 && !rise_pending(); i++) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clrrise_edges", edges, 0);
        chk("clrrise_level", ts_level, 0);
        chk("clrrise_overflow", overflow, 0);
        repeat (6) step();

        // Randomised traffic.
        repeat (400) begin
            en       = CHANNELS'($urandom);
            sel      = SEL_W'($urandom_range(0, CHANNELS - 1));
            ts_ready = 1'($urandom_range(0, 1));
            clr      = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 149) == 0) async_reset();
            else step();
        end
        clr = 1'b0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
